// File: rtl/weyl_stream_decoder.sv
// rtl/weyl_stream_decoder.sv - Weyl-permuted stochastic bitstream decoder (frame popcount)
// Optional canonical-frame checker: define WEYL_DEC_CHECK_EN.
module weyl_stream_decoder #(
    parameter int BITSTREAM = 64,
    parameter int LANES     = 8,
    parameter int BASE      = 61,
    parameter int STRIDE    = 17
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [LANES-1:0]            in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [$clog2(BITSTREAM):0]  out_quota,
    output logic                        out_mismatch
);
    localparam int BEATS = BITSTREAM / LANES;
    localparam int QW    = $clog2(BITSTREAM) + 1;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

    typedef enum logic [1:0] {COLLECT, CHECK, HOLD} state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [CW-1:0] r_beat_cnt;
    logic [QW-1:0] r_acc;
    logic [QW-1:0] r_quota;
    logic [QW-1:0] w_beat_ones;
    logic          w_beat_xfer;
    logic          w_last_beat;

    if ((STRIDE % 2) == 0 || BASE < 0 || (BITSTREAM % LANES) != 0) begin : g_bad_params
        $error("weyl_stream_decoder: STRIDE must be odd, BASE >= 0, LANES must divide BITSTREAM");
    end

    function automatic logic [QW-1:0] popcount(input logic [LANES-1:0] d);
        logic [QW-1:0] n;
        n = '0;
        for (int i = 0; i < LANES; i++) n = n + QW'(d[i]);
        return n;
    endfunction

    always_comb begin
        w_beat_ones  = popcount(in_data);
        in_ready     = (r_state == COLLECT) && !rst;
        out_valid    = (r_state == HOLD);
        w_beat_xfer  = in_valid && in_ready;
        w_last_beat  = w_beat_xfer && (r_beat_cnt == LAST_BEAT);
        w_state_next = r_state;
        case (r_state)
            COLLECT: begin
                if (w_last_beat) begin
`ifdef WEYL_DEC_CHECK_EN
                    w_state_next = CHECK;
`else
                    w_state_next = HOLD;
`endif
                end
            end
            CHECK:   w_state_next = HOLD;
            HOLD:    if (out_ready) w_state_next = COLLECT;
            default: w_state_next = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= COLLECT;
            r_beat_cnt <= '0;
            r_acc      <= '0;
            r_quota    <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_beat_xfer) begin
                if (w_last_beat) begin
                    r_quota    <= r_acc + w_beat_ones;
                    r_acc      <= '0;
                    r_beat_cnt <= '0;
                end else begin
                    r_acc      <= r_acc + w_beat_ones;
                    r_beat_cnt <= r_beat_cnt + 1'b1;
                end
            end
        end
    end

    assign out_quota = r_quota;

`ifdef WEYL_DEC_CHECK_EN
    localparam int AW = $clog2(BITSTREAM);

    logic [BITSTREAM-1:0] r_frame;
    logic [BITSTREAM-1:0] w_expected;
    logic [AW-1:0]        w_idx;
    logic                 r_mismatch;

    // Canonical encoder output for the recovered quota: the first q Weyl positions are ones.
    always_comb begin
        w_expected = '0;
        w_idx      = '0;
        for (int i = 0; i < BITSTREAM; i++) begin
            w_idx             = AW'((BASE + i * STRIDE) % BITSTREAM);
            w_expected[w_idx] = (i < int'(r_quota));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame    <= '0;
            r_mismatch <= 1'b0;
        end else begin
            if (w_beat_xfer) r_frame[r_beat_cnt * LANES +: LANES] <= in_data;
            if (r_state == CHECK) r_mismatch <= (r_frame != w_expected);
        end
    end

    assign out_mismatch = r_mismatch;
`else
    assign out_mismatch = 1'b0;
`endif
endmodule

// File: tb/tb_weyl_stream_decoder.sv
// tb/tb_weyl_stream_decoder.sv - randomized self-checking bench for weyl_stream_decoder
`timescale 1ns/1ps
module tb_weyl_stream_decoder;
    localparam int BS = 64, LN = 8, NB = BS / LN, BASE = 61, STRIDE = 17;
`ifdef WEYL_DEC_CHECK_EN
    localparam int LAT = 2;
    localparam bit CHK = 1'b1;
`else
    localparam int LAT = 1;
    localparam bit CHK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [LN-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [6:0]    out_quota;
    logic          out_mismatch;
    int            checks = 0;
    int            errors = 0;

    always #5 clk = ~clk;

    weyl_stream_decoder #(.BITSTREAM(BS), .LANES(LN), .BASE(BASE), .STRIDE(STRIDE)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_quota(out_quota), .out_mismatch(out_mismatch)
    );

    // Encoder model: walk the Weyl sequence and set the first q visited positions.
    function automatic logic [BS-1:0] weyl_frame(input int q);
        logic [BS-1:0] f;
        int pos;
        f = '0;
        pos = BASE % BS;
        for (int n = 0; n < q; n++) begin
            f[pos] = 1'b1;
            pos = (pos + STRIDE) % BS;
        end
        return f;
    endfunction

    function automatic int count_ones(input logic [BS-1:0] f);
        int c;
        c = 0;
        for (int i = 0; i < BS; i++) if (f[i]) c++;
        return c;
    endfunction

    function automatic logic expect_mm(input logic [BS-1:0] f);
        return CHK ? (f != weyl_frame(count_ones(f))) : 1'b0;
    endfunction

    task automatic send_frame(input logic [BS-1:0] f, input int gap_pct, output bit timed_out);
        timed_out = 1'b0;
        for (int k = 0; k < NB; k++) begin
            int budget;
            bit done;
            budget = 0;
            done = 1'b0;
            while (!done) begin
                @(negedge clk);
                if (int'($urandom_range(99)) < gap_pct) begin
                    in_valid = 1'b0;
                    in_data  = LN'($urandom);
                end else begin
                    in_valid = 1'b1;
                    in_data  = f[k*LN +: LN];
                    done     = in_ready;
                end
                budget++;
                if (!done && budget > 200) begin
                    timed_out = 1'b1;
                    return;
                end
            end
        end
    endtask

    task automatic wait_result(input bit rdy, output int lat);
        lat = 0;
        repeat (20) begin
            @(negedge clk);
            lat++;
            in_valid  = 1'b0;
            out_ready = rdy;
            if (out_valid) return;
        end
        lat = -1;
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks += 4;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        if (out_quota !== 7'd0) begin errors++; $display("FAIL reset_out_quota: got %0d expected 0", out_quota); end
        if (out_mismatch !== 1'b0) begin errors++; $display("FAIL reset_mismatch: got %b expected 0", out_mismatch); end
        if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_extremes;
        logic [BS-1:0] f;
        bit to;
        int lat;
        for (int p = 0; p < 2; p++) begin
            f = (p == 0) ? '0 : '1;
            send_frame(f, 0, to);
            wait_result(1'b1, lat);
            checks += 5;
            if (to) begin errors++; $display("FAIL extremes_send_timeout: pattern %0d", p); end
            if (lat != LAT) begin errors++; $display("FAIL extremes_latency: got %0d expected %0d", lat, LAT); end
            if (out_quota !== 7'(count_ones(f))) begin errors++; $display("FAIL extremes_quota: got %0d expected %0d", out_quota, count_ones(f)); end
            if (out_mismatch !== expect_mm(f)) begin errors++; $display("FAIL extremes_mismatch: got %b expected %b", out_mismatch, expect_mm(f)); end
            @(negedge clk);
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL extremes_single_pulse: got valid=%b ready=%b expected 0/1", out_valid, in_ready); end
        end
    endtask

    task automatic test_weyl_gaps;
        logic [BS-1:0] f;
        bit to;
        int lat;
        f = weyl_frame(37);
        send_frame(f, 40, to);
        wait_result(1'b1, lat);
        checks += 4;
        if (to) begin errors++; $display("FAIL gaps_send_timeout: got timeout expected none"); end
        if (lat != LAT) begin errors++; $display("FAIL gaps_latency: got %0d expected %0d", lat, LAT); end
        if (out_quota !== 7'd37) begin errors++; $display("FAIL gaps_quota: got %0d expected 37", out_quota); end
        if (out_mismatch !== 1'b0) begin errors++; $display("FAIL gaps_mismatch: got %b expected 0", out_mismatch); end
        @(negedge clk);
    endtask

    task automatic test_backpressure;
        bit to;
        int lat;
        send_frame(weyl_frame(20), 0, to);
        wait_result(1'b0, lat);
        checks += 2;
        if (lat != LAT) begin errors++; $display("FAIL bp_latency: got %0d expected %0d", lat, LAT); end
        if (out_quota !== 7'd20) begin errors++; $display("FAIL bp_quota: got %0d expected 20", out_quota); end
        repeat (5) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 8'hFF;
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_quota !== 7'd20) begin
                errors++;
                $display("FAIL bp_hold: got ready=%b valid=%b quota=%0d expected 0/1/20", in_ready, out_valid, out_quota);
            end
        end
        @(negedge clk);
        out_ready = 1'b1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_same_cycle: got %b expected 0", in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_release: got valid=%b ready=%b expected 0/1", out_valid, in_ready); end
        send_frame(weyl_frame(5), 0, to);
        wait_result(1'b1, lat);
        checks++;
        if (out_quota !== 7'd5) begin errors++; $display("FAIL bp_next_quota: got %0d expected 5", out_quota); end
        @(negedge clk);
    endtask

    task automatic test_mid_reset;
        bit to;
        int lat;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 8'hFF;
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL midrst_in_ready: got %b expected 0", in_ready); end
        @(negedge clk);
        rst = 1'b0;
        send_frame(weyl_frame(10), 20, to);
        wait_result(1'b1, lat);
        checks += 2;
        if (lat != LAT) begin errors++; $display("FAIL midrst_latency: got %0d expected %0d", lat, LAT); end
        if (out_quota !== 7'd10) begin errors++; $display("FAIL midrst_quota: got %0d expected 10", out_quota); end
        @(negedge clk);
        send_frame(weyl_frame(50), 0, to);
        wait_result(1'b0, lat);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || out_quota !== 7'd0) begin errors++; $display("FAIL holdrst_drop: got valid=%b quota=%0d expected 0/0", out_valid, out_quota); end
        send_frame(weyl_frame(3), 0, to);
        wait_result(1'b1, lat);
        checks++;
        if (out_quota !== 7'd3) begin errors++; $display("FAIL holdrst_next_quota: got %0d expected 3", out_quota); end
        @(negedge clk);
    endtask

    task automatic test_corrupt;
        logic [BS-1:0] f;
        bit to;
        int lat;
        f = weyl_frame(37);
        f[BASE % BS] = 1'b0;
        send_frame(f, 0, to);
        wait_result(1'b1, lat);
        checks += 3;
        if (lat != LAT) begin errors++; $display("FAIL corrupt_latency: got %0d expected %0d", lat, LAT); end
        if (out_quota !== 7'd36) begin errors++; $display("FAIL corrupt_quota: got %0d expected 36", out_quota); end
        if (out_mismatch !== CHK) begin errors++; $display("FAIL corrupt_mismatch: got %b expected %b", out_mismatch, CHK); end
        @(negedge clk);
    endtask

    task automatic test_random;
        logic [BS-1:0] f;
        bit to;
        int lat, hold;
        for (int n = 0; n < 12; n++) begin
            f = {$urandom, $urandom};
            case ($urandom_range(3))
                0: f = f & {$urandom, $urandom};
                1: f = f | {$urandom, $urandom};
                2: f = weyl_frame(int'($urandom_range(BS)));
                default: ;
            endcase
            hold = int'($urandom_range(3));
            send_frame(f, int'($urandom_range(50)), to);
            wait_result(hold == 0, lat);
            checks += 3;
            if (lat != LAT) begin errors++; $display("FAIL rand_latency: frame %0d got %0d expected %0d", n, lat, LAT); end
            if (out_quota !== 7'(count_ones(f))) begin errors++; $display("FAIL rand_quota: frame %0d got %0d expected %0d", n, out_quota, count_ones(f)); end
            if (out_mismatch !== expect_mm(f)) begin errors++; $display("FAIL rand_mismatch: frame %0d got %b expected %b", n, out_mismatch, expect_mm(f)); end
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                checks++;
                if (out_valid !== 1'b1 || out_quota !== 7'(count_ones(f))) begin
                    errors++;
                    $display("FAIL rand_hold: frame %0d got valid=%b quota=%0d expected 1/%0d", n, out_valid, out_quota, count_ones(f));
                end
                if (h == hold - 1) out_ready = 1'b1;
            end
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL rand_release: frame %0d got %b expected 0", n, out_valid); end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_extremes();
        test_weyl_gaps();
        test_backpressure();
        test_mid_reset();
        test_corrupt();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
